// File: rtl/configurable_uart_transmitter.sv
// UART transmit channel: runtime-configurable length, parity and stop bits,
// per-bit prescale counter and a one-entry holding buffer for back-to-back frames.
module configurable_uart_transmitter #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    input  logic [$clog2(DATA_WIDTH):0]   data_length,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          two_stop_bits,
    input  logic                          data_valid,
    input  logic [DATA_WIDTH-1:0]         parallel_data,
    output logic                          data_ready,
    output logic                          serial_data_out,
    output logic                          busy
);
    localparam int LW = $clog2(DATA_WIDTH) + 1;
    localparam logic [LW-1:0] MIN_L = LW'(5);
    localparam logic [LW-1:0] MAX_L = LW'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic                      buf_full;
    logic [DATA_WIDTH-1:0]     buf_data, shreg, len_mask;
    logic [PRESCALE_WIDTH-1:0] p_lat, cnt;
    logic [LW-1:0]             l_lat, bit_idx, len_clamped;
    logic                      par_en, par_bit, two_stop, stop_idx;
    logic                      bit_end, last_data, last_stop, load, accept, par_next;

    // Parity is computed from the buffered word at load time so only the
    // active bits contribute.
    always_comb begin
        len_clamped = data_length;
        if (data_length < MIN_L)
            len_clamped = MIN_L;
        else if (data_length > MAX_L)
            len_clamped = MAX_L;
        len_mask = ~({DATA_WIDTH{1'b1}} << len_clamped);
        par_next = (^(buf_data & len_mask)) ^ parity_type;
    end

    assign bit_end   = (cnt == p_lat - PRESCALE_WIDTH'(1));
    assign last_data = (bit_idx == l_lat - LW'(1));
    assign last_stop = (state == STOP) && bit_end && (stop_idx == two_stop);
    assign load      = buf_full && ((state == IDLE) || last_stop);
    assign accept    = data_valid && !buf_full;

    assign data_ready = !buf_full;
    assign busy       = (state != IDLE) || buf_full;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = START;
            START:   if (bit_end) state_n = DATA;
            DATA:    if (bit_end && last_data) state_n = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_n = STOP;
            STOP:    if (last_stop) state_n = load ? START : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full        <= 1'b0;
            buf_data        <= '0;
            shreg           <= '0;
            p_lat           <= '0;
            cnt             <= '0;
            l_lat           <= '0;
            bit_idx         <= '0;
            par_en          <= 1'b0;
            par_bit         <= 1'b0;
            two_stop        <= 1'b0;
            stop_idx        <= 1'b0;
            serial_data_out <= 1'b1;
        end else begin
            if (accept) begin
                buf_data <= parallel_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (load) begin
                shreg           <= buf_data;
                p_lat           <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
                l_lat           <= len_clamped;
                par_en          <= parity_enable;
                par_bit         <= par_next;
                two_stop        <= two_stop_bits;
                cnt             <= '0;
                bit_idx         <= '0;
                stop_idx        <= 1'b0;
                serial_data_out <= 1'b0;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt + PRESCALE_WIDTH'(1);
                end else begin
                    cnt <= '0;
                    // Line is registered: drive the value of the bit about to start.
                    case (state)
                        START: serial_data_out <= shreg[0];
                        DATA: begin
                            if (last_data) begin
                                serial_data_out <= par_en ? par_bit : 1'b1;
                            end else begin
                                bit_idx         <= bit_idx + LW'(1);
                                shreg           <= shreg >> 1;
                                serial_data_out <= shreg[1];
                            end
                        end
                        STOP: begin
                            stop_idx        <= 1'b1;
                            serial_data_out <= 1'b1;
                        end
                        default: serial_data_out <= 1'b1;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_configurable_uart_transmitter.sv
// Directed bench: table of frames with hand-computed bit patterns plus
// sequences for back-to-back, mid-frame config change and reset abort.
module tb_configurable_uart_transmitter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] prescale;
    logic [3:0]  data_length;
    logic        parity_enable, parity_type, two_stop_bits;
    logic        data_valid;
    logic [7:0]  parallel_data;
    logic        data_ready, serial_data_out, busy;

    int errors = 0;
    int checks = 0;

    configurable_uart_transmitter #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .prescale(prescale), .data_length(data_length),
        .parity_enable(parity_enable), .parity_type(parity_type),
        .two_stop_bits(two_stop_bits), .data_valid(data_valid),
        .parallel_data(parallel_data), .data_ready(data_ready),
        .serial_data_out(serial_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pre;
        logic [3:0]  len;
        logic        pe, pt, ts;
        logic [7:0]  data;
        logic [15:0] frame;   // bit k = k-th bit on the line
        int          nbits;
        int          p_eff;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_cycle(input string tag, input logic exp_line);
        chk({tag, " line"}, 32'(serial_data_out), 32'(exp_line));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        next_cycle();
    endtask

    // Checks a whole frame cycle by cycle, skipping cycles already consumed.
    task automatic check_bits(input string tag, input logic [15:0] fr, input int nb,
                              input int p, input int skip);
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < p; c++)
                if (k * p + c >= skip)
                    expect_cycle($sformatf("%s bit%0d cyc%0d", tag, k, c), fr[k]);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle line"},  32'(serial_data_out), 32'd1);
        chk({tag, " idle busy"},  32'(busy),            32'd0);
        chk({tag, " idle ready"}, 32'(data_ready),      32'd1);
    endtask

    task automatic set_cfg(input vec_t v);
        prescale      = v.pre;
        data_length   = v.len;
        parity_enable = v.pe;
        parity_type   = v.pt;
        two_stop_bits = v.ts;
    endtask

    // Handshake at the next edge; returns at the negedge after it (buf_full cycle).
    task automatic offer(input string tag, input logic [7:0] d);
        chk({tag, " ready before"}, 32'(data_ready), 32'd1);
        parallel_data = d;
        data_valid    = 1'b1;
        next_cycle();
    endtask

    task automatic send_vec(input string tag, input vec_t v);
        set_cfg(v);
        offer(tag, v.data);
        data_valid = 1'b0;
        chk({tag, " latency line"}, 32'(serial_data_out), 32'd1);
        chk({tag, " full ready"},   32'(data_ready),      32'd0);
        chk({tag, " full busy"},    32'(busy),            32'd1);
        next_cycle();
        check_bits(tag, v.frame, v.nbits, v.p_eff, 0);
        check_idle(tag);
    endtask

    initial begin
        vecs[0] = '{16'd4, 4'd8,  1'b0, 1'b0, 1'b0, 8'hA5, 16'h034A, 10, 4};
        vecs[1] = '{16'd2, 4'd7,  1'b1, 1'b0, 1'b1, 8'h53, 16'h06A6, 11, 2};
        vecs[2] = '{16'd2, 4'd7,  1'b1, 1'b1, 1'b1, 8'h53, 16'h07A6, 11, 2};
        vecs[3] = '{16'd0, 4'd8,  1'b0, 1'b0, 1'b0, 8'h3C, 16'h0278, 10, 1};
        vecs[4] = '{16'd1, 4'd8,  1'b0, 1'b0, 1'b0, 8'h3C, 16'h0278, 10, 1};
        vecs[5] = '{16'd1, 4'd3,  1'b0, 1'b0, 1'b0, 8'h35, 16'h006A, 7,  1};
        vecs[6] = '{16'd1, 4'd3,  1'b1, 1'b0, 1'b0, 8'h35, 16'h00EA, 8,  1};
        vecs[7] = '{16'd1, 4'd12, 1'b0, 1'b0, 1'b0, 8'h81, 16'h0302, 10, 1};
        vecs[8] = '{16'd3, 4'd15, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0E00, 12, 3};

        // Reset with data_valid asserted: the offer must be ignored.
        reset = 1'b1;
        set_cfg(vecs[0]);
        data_valid    = 1'b1;
        parallel_data = 8'hFF;
        @(negedge clk);
        repeat (3) next_cycle();
        check_idle("in reset");
        data_valid = 1'b0;
        reset      = 1'b0;
        next_cycle();
        check_idle("after reset");

        for (int i = 0; i < 9; i++)
            send_vec($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: second word held on data_valid until accepted.
        set_cfg('{16'd2, 4'd5, 1'b0, 1'b0, 1'b0, 8'h35, 16'h006A, 7, 2});
        offer("b2b", 8'h35);
        parallel_data = 8'hCA;
        chk("b2b ready while full", 32'(data_ready), 32'd0);
        next_cycle();
        chk("b2b ready after load", 32'(data_ready), 32'd1);
        expect_cycle("b2b f1 bit0 cyc0", 1'b0);
        data_valid = 1'b0;
        chk("b2b ready after accept", 32'(data_ready), 32'd0);
        check_bits("b2b f1", 16'h006A, 7, 2, 1);
        check_bits("b2b f2", 16'h0054, 7, 2, 0);
        check_idle("b2b end");

        // Mid-frame config change affects only the following frame.
        set_cfg(vecs[0]);
        prescale = 16'd2;
        offer("cfgchg", 8'hA5);
        data_valid = 1'b0;
        next_cycle();
        expect_cycle("cfgchg bit0 cyc0", 1'b0);
        prescale    = 16'd1;
        data_length = 4'd5;
        check_bits("cfgchg", 16'h034A, 10, 2, 1);
        check_idle("cfgchg end");
        send_vec("cfgchg next", '{16'd1, 4'd5, 1'b0, 1'b0, 1'b0, 8'h35, 16'h006A, 7, 1});

        // Reset during DATA with a word buffered aborts everything.
        set_cfg(vecs[0]);
        offer("rst", 8'hA5);
        parallel_data = 8'h5A;
        next_cycle();
        next_cycle();
        data_valid = 1'b0;
        chk("rst buffered", 32'(data_ready), 32'd0);
        repeat (5) next_cycle();
        chk("rst in data busy", 32'(busy), 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_idle("rst abort");
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("rst quiet line%0d", i), 32'(serial_data_out), 32'd1);
            chk($sformatf("rst quiet busy%0d", i), 32'(busy), 32'd0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
